// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end.
package cpu_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry valid/ready output register carrying an instruction word and its PC.
module fetch_out_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  logic accept;

  assign accept = inst_valid && ready;

  // Flush beats load; an accept only empties the stage when nothing refills it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst       <= load_inst;
      inst_pc    <= load_pc;
    end else if (accept) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, ROM read port, redirect/halt/fault FSM.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic              fault
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              redir_live;
  logic              redir_bad;
  logic              redir_go;
  logic              fetch;

  always_comb begin
    redir_live = redirect_valid && ((state == ST_FETCH) || (state == ST_HALT));
    redir_bad  = redir_live && (redirect_pc[1:0] != 2'b00);
    redir_go   = redir_live && (redirect_pc[1:0] == 2'b00);
    fetch      = (state == ST_FETCH) && !redirect_valid && !halt_req
                 && (!inst_valid || inst_ready);
  end

  assign rom_en   = fetch;
  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_BOOT;
      pc     <= ADDR_W'(RESET_PC);
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
        end
        ST_FETCH, ST_HALT: begin
          if (redir_bad) begin
            state  <= ST_FAULT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else if (redir_go) begin
            pc     <= redirect_pc;
            state  <= halt_req ? ST_HALT : ST_FETCH;
            halted <= halt_req;
          end else if (halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state  <= ST_FETCH;
            halted <= 1'b0;
            if (fetch) pc <= pc + ADDR_W'(PC_STEP);
          end
        end
        default: begin
          state  <= ST_FAULT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  fetch_out_stage #(
    .ADDR_W(ADDR_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fetch),
    .flush     (redir_live),
    .ready     (inst_ready),
    .load_inst (rom_data),
    .load_pc   (pc),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

endmodule
